// File: rtl/drp_pkg.sv
// Shared definitions for the DRP sample responder: register addresses, FSM
// states and the sample-channel to DRP-address mapping.
package drp_pkg;

    localparam logic [6:0] ADDR_AUX6  = 7'h16;
    localparam logic [6:0] ADDR_AUX7  = 7'h17;
    localparam logic [6:0] ADDR_AUX14 = 7'h1E;
    localparam logic [6:0] ADDR_AUX15 = 7'h1F;
    localparam logic [6:0] ADDR_CTRL  = 7'h40;
    localparam logic [6:0] ADDR_STAT  = 7'h41;

    // ctrl bit1 is a write-1 strobe and is never stored
    localparam logic [15:0] CTRL_STORE_MASK = 16'hFFFD;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } drp_state_t;

    function automatic logic [6:0] chan_to_addr(input logic [1:0] chan);
        case (chan)
            2'd0:    return ADDR_AUX14;
            2'd1:    return ADDR_AUX7;
            2'd2:    return ADDR_AUX15;
            default: return ADDR_AUX6;
        endcase
    endfunction

endpackage

// File: rtl/drp_result_bank.sv
// Four sample result registers with read mux. Defining DRP_SAMPLE_AVG_EN turns
// each register into a 4-sample IIR average instead of a plain latch of s_data.
module drp_result_bank
    import drp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wr_en,
    input  logic [1:0]  wr_chan,
    input  logic [15:0] wr_data,
    input  logic [6:0]  rd_addr,
    output logic        rd_hit,
    output logic [15:0] rd_data
);

    logic [15:0] res [4];
    logic [15:0] next_val;

`ifdef DRP_SAMPLE_AVG_EN
    logic [3:0]         primed;
    logic signed [17:0] diff;
    logic signed [17:0] sum;

    always_comb begin
        diff     = $signed({2'b00, wr_data}) - $signed({2'b00, res[wr_chan]});
        sum      = $signed({2'b00, res[wr_chan]}) + (diff >>> 2);
        next_val = primed[wr_chan] ? sum[15:0] : wr_data;
    end

    // While sampling is disabled every channel forgets its history, so the
    // first sample after enable rises loads directly.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            primed <= '0;
        end else if (wr_en) begin
            primed[wr_chan] <= 1'b1;
        end
    end
`else
    logic unused_en;

    assign unused_en = en;
    assign next_val  = wr_data;
`endif

    // NOTE: the result array is only four words, so it is built from flops and
    // reset explicitly; reads straight after rst must return 0, not RAM garbage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) res[i] <= '0;
        end else if (wr_en) begin
            res[wr_chan] <= next_val;
        end
    end

    // NOTE: both outputs get a default before the search loop so no path
    // through this block can leave them unassigned and infer a latch.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            if (rd_addr == chan_to_addr(2'(i))) begin
                rd_hit  = 1'b1;
                rd_data = res[i];
            end
        end
    end

endmodule

// File: rtl/drp_sample_responder.sv
// DRP responder serving filtered samples at the XADC aux channel addresses,
// with fixed read latency, ctrl/status registers and eoc generation.
// Optional averaging in the result bank is enabled by DRP_SAMPLE_AVG_EN.
module drp_sample_responder
    import drp_pkg::*;
#(
    parameter int          READ_LAT   = 4,
    parameter logic [15:0] CTRL_RESET = 16'h0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        den,
    input  logic        dwe,
    input  logic [6:0]  daddr,
    input  logic [15:0] di,
    output logic [15:0] do_out,
    output logic        drdy,
    output logic        eoc,
    output logic [6:0]  chan_out,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [1:0]  s_chan,
    input  logic [15:0] s_data
);

    localparam logic [3:0] LAT_LOAD = 4'(READ_LAT - 1);

    drp_state_t  state;
    logic [3:0]  lat_cnt;
    logic [6:0]  req_addr;
    logic        req_we;
    logic [15:0] req_di;
    logic [15:0] snap;

    logic [15:0] ctrl;
    logic        err;
    logic [7:0]  smp_cnt;

    logic        busy;
    logic        smp_fire;
    logic        ctrl_wr;
    logic        err_set;
    logic        err_clr;
    logic        bank_hit;
    logic [15:0] bank_data;
    logic [15:0] reg_rd;

    assign s_ready  = ctrl[0];
    assign smp_fire = s_valid && s_ready;
    assign busy     = (state != ST_IDLE);
    assign ctrl_wr  = (state == ST_ACK) && req_we && (req_addr == ADDR_CTRL);
    assign err_set  = den && busy;
    assign err_clr  = ctrl_wr && req_di[1];

    drp_result_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .en      (ctrl[0]),
        .wr_en   (smp_fire),
        .wr_chan (s_chan),
        .wr_data (s_data),
        .rd_addr (daddr),
        .rd_hit  (bank_hit),
        .rd_data (bank_data)
    );

    // Read value for the address presented this cycle; sampled only on den in IDLE
    always_comb begin
        reg_rd = 16'h0000;
        if (bank_hit) begin
            reg_rd = bank_data;
        end else if (daddr == ADDR_CTRL) begin
            reg_rd = ctrl & CTRL_STORE_MASK;
        end else if (daddr == ADDR_STAT) begin
            reg_rd = {smp_cnt, 6'b000000, busy, err};
        end
    end

    // NOTE: every register here is state, so all updates are non-blocking; each
    // right-hand side sees pre-edge values, which gives reads the old sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            lat_cnt  <= '0;
            req_addr <= '0;
            req_we   <= 1'b0;
            req_di   <= '0;
            snap     <= '0;
            ctrl     <= CTRL_RESET & CTRL_STORE_MASK;
            err      <= 1'b0;
            smp_cnt  <= '0;
            do_out   <= '0;
            drdy     <= 1'b0;
            eoc      <= 1'b0;
            chan_out <= '0;
        end else begin
            drdy   <= 1'b0;
            do_out <= '0;
            eoc    <= smp_fire;
            err    <= err_set | (err & ~err_clr);

            if (smp_fire) begin
                chan_out <= chan_to_addr(s_chan);
                smp_cnt  <= smp_cnt + 8'd1;
            end

            if (ctrl_wr) begin
                ctrl <= req_di & CTRL_STORE_MASK;
            end

            case (state)
                ST_IDLE: begin
                    if (den) begin
                        req_addr <= daddr;
                        req_we   <= dwe;
                        req_di   <= di;
                        snap     <= dwe ? 16'h0000 : reg_rd;
                        if (READ_LAT == 1) begin
                            state  <= ST_ACK;
                            drdy   <= 1'b1;
                            do_out <= dwe ? 16'h0000 : reg_rd;
                        end else begin
                            lat_cnt <= LAT_LOAD;
                            state   <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        state  <= ST_ACK;
                        drdy   <= 1'b1;
                        do_out <= snap;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drp_sample_responder.sv
// Self-checking bench: cycle-level timeline model of the DRP register map and
// sample path, compared against the DUT every cycle, plus directed scenarios.
module tb_drp_sample_responder;

    localparam int          READ_LAT   = 4;
    localparam logic [15:0] CTRL_RESET = 16'h0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        den;
    logic        dwe;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] do_out;
    logic        drdy;
    logic        eoc;
    logic [6:0]  chan_out;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  s_chan;
    logic [15:0] s_data;

    always #5 clk = ~clk;

    drp_sample_responder #(
        .READ_LAT   (READ_LAT),
        .CTRL_RESET (CTRL_RESET)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .den      (den),
        .dwe      (dwe),
        .daddr    (daddr),
        .di       (di),
        .do_out   (do_out),
        .drdy     (drdy),
        .eoc      (eoc),
        .chan_out (chan_out),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_chan   (s_chan),
        .s_data   (s_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0]  chan_addr [4] = '{7'h1E, 7'h17, 7'h1F, 7'h16};
    logic [15:0] m_res [4];
    logic [15:0] m_ctrl;
    bit          m_err;
    bit   [7:0]  m_cnt;
    bit   [3:0]  m_primed;
    bit          m_pend;
    int          m_ack_at;
    bit          m_we;
    logic [6:0]  m_addr;
    logic [15:0] m_di;
    logic [15:0] m_snap;
    int          cyc = 0;

    bit          e_drdy;
    bit          e_eoc;
    logic [15:0] e_do;
    logic [6:0]  e_chan;

    bit          seen_drdy;
    logic [15:0] last_rd;
    int          drdy_count;

    function automatic logic [15:0] model_read(input logic [6:0] a);
        for (int i = 0; i < 4; i++) if (a == chan_addr[i]) return m_res[i];
        if (a == 7'h40) return m_ctrl & 16'hFFFD;
        if (a == 7'h41) return {m_cnt, 8'h00} | {15'd0, m_err};
        return 16'h0000;
    endfunction

    // Consume the inputs of cycle cyc and produce the expected outputs of cyc+1
    task automatic model_step();
        bit          busy;
        bit          ack_now;
        bit          fire;
        logic [15:0] rd;
        int          d;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_res[i] = 16'h0000;
            m_ctrl   = CTRL_RESET & 16'hFFFD;
            m_err    = 0;
            m_cnt    = 0;
            m_primed = 0;
            m_pend   = 0;
            e_drdy   = 0;
            e_eoc    = 0;
            e_do     = 0;
            e_chan   = 0;
            cyc++;
            return;
        end
        busy    = m_pend;
        ack_now = m_pend && (m_ack_at == cyc);
        rd      = model_read(daddr);
        fire    = s_valid && m_ctrl[0];

        if (!m_ctrl[0]) m_primed = 0;
        if (fire) begin
`ifdef DRP_SAMPLE_AVG_EN
            if (m_primed[s_chan]) begin
                d = int'(s_data) - int'(m_res[s_chan]);
                m_res[s_chan] = 16'(int'(m_res[s_chan]) + (d >>> 2));
            end else begin
                m_res[s_chan] = s_data;
            end
            m_primed[s_chan] = 1;
`else
            d = 0;
            m_res[s_chan] = s_data;
`endif
            m_cnt++;
            e_chan = chan_addr[s_chan];
        end
        e_eoc = fire;

        if (ack_now) begin
            if (m_we && m_addr == 7'h40) begin
                m_ctrl = m_di & 16'hFFFD;
                if (m_di[1]) m_err = 0;
            end
            m_pend = 0;
        end
        if (den) begin
            if (busy) begin
                m_err = 1;
            end else begin
                m_pend   = 1;
                m_ack_at = cyc + READ_LAT;
                m_we     = dwe;
                m_addr   = daddr;
                m_di     = di;
                m_snap   = dwe ? 16'h0000 : rd;
            end
        end
        e_drdy = m_pend && (m_ack_at == cyc + 1);
        e_do   = e_drdy ? m_snap : 16'h0000;
        cyc++;
    endtask

    task automatic compare();
        check("drdy", 32'(drdy), 32'(e_drdy));
        check("eoc", 32'(eoc), 32'(e_eoc));
        check("chan_out", 32'(chan_out), 32'(e_chan));
        check("s_ready", 32'(s_ready), 32'(m_ctrl[0]));
        if (e_drdy) check("do_out", 32'(do_out), 32'(e_do));
        if (drdy === 1'b1) begin
            seen_drdy = 1;
            last_rd   = do_out;
            drdy_count++;
        end
    endtask

    // Inputs set before tick() are sampled at the next posedge; outputs are
    // compared at the following negedge.
    task automatic tick();
        model_step();
        @(negedge clk);
        compare();
        den     = 1'b0;
        s_valid = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic drp_op(input bit we, input logic [6:0] a, input logic [15:0] data,
                          output logic [15:0] rdata, output int lat);
        den       = 1'b1;
        dwe       = we;
        daddr     = a;
        di        = data;
        seen_drdy = 0;
        lat       = 0;
        do begin
            tick();
            lat++;
        end while (!seen_drdy && lat < 40);
        if (!seen_drdy) check("drdy_timeout", 32'd0, 32'd1);
        rdata = last_rd;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] rd;
    int          lat;

    initial begin
        rst = 1'b1; den = 1'b0; dwe = 1'b0; daddr = '0; di = '0;
        s_valid = 1'b0; s_chan = '0; s_data = '0;
        drdy_count = 0;
        @(negedge clk);
        rst = 1'b1; tick();
        rst = 1'b1; tick();
        check("rst_s_ready", 32'(s_ready), 32'd1);

        // 1: read 0x1E after reset
        drp_op(1'b0, 7'h1E, 16'h0, rd, lat);
        check("t1_latency", 32'(lat), 32'(READ_LAT));
        check("t1_data", 32'(rd), 32'h0000);
        check("t1_drdy_pulse", 32'(drdy), 32'd0);

        // 2: sample on chan 1
        s_valid = 1'b1; s_chan = 2'd1; s_data = 16'hA5C0;
        tick();
        check("t2_eoc", 32'(eoc), 32'd1);
        check("t2_chan", 32'(chan_out), 32'h17);
        tick();
        check("t2_eoc_pulse", 32'(eoc), 32'd0);
        drp_op(1'b0, 7'h17, 16'h0, rd, lat);
        check("t2_read", 32'(rd), 32'hA5C0);

        // 3: den while busy is dropped and sets err; write-1 clears it
        drdy_count = 0;
        den = 1'b1; dwe = 1'b0; daddr = 7'h1E;
        tick();
        tick();
        den = 1'b1; daddr = 7'h1E;
        tick();
        repeat (8) tick();
        check("t3_one_drdy", 32'(drdy_count), 32'd1);
        drp_op(1'b0, 7'h41, 16'h0, rd, lat);
        check("t3_err_set", 32'(rd[0]), 32'd1);
        drp_op(1'b1, 7'h40, 16'h0003, rd, lat);
        drp_op(1'b0, 7'h41, 16'h0, rd, lat);
        check("t3_err_clr", 32'(rd[0]), 32'd0);
        drp_op(1'b0, 7'h40, 16'h0, rd, lat);
        check("t3_ctrl", 32'(rd), 32'h0001);

        // 4: sampling disabled
        drp_op(1'b1, 7'h40, 16'h0000, rd, lat);
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_chan = 2'd0; s_data = 16'h1230;
            tick();
            check("t4_s_ready", 32'(s_ready), 32'd0);
            check("t4_no_eoc", 32'(eoc), 32'd0);
        end
        drp_op(1'b0, 7'h1E, 16'h0, rd, lat);
        check("t4_1e", 32'(rd), 32'h0000);
        drp_op(1'b0, 7'h41, 16'h0, rd, lat);
        check("t4_count", 32'(rd[15:8]), 32'd1);
        drp_op(1'b1, 7'h40, 16'h0001, rd, lat);

        // 5: unmapped read, write to read-only result
        drp_op(1'b0, 7'h05, 16'h0, rd, lat);
        check("t5_latency", 32'(lat), 32'(READ_LAT));
        check("t5_data", 32'(rd), 32'h0000);
        drp_op(1'b1, 7'h1F, 16'hBEEF, rd, lat);
        drp_op(1'b0, 7'h1F, 16'h0, rd, lat);
        check("t5_1f", 32'(rd), 32'h0000);

        // 6: reset during WAIT abandons the transaction
        drdy_count = 0;
        den = 1'b1; dwe = 1'b0; daddr = 7'h17;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("t6_drdy", 32'(drdy), 32'd0);
        check("t6_do_out", 32'(do_out), 32'd0);
        check("t6_eoc", 32'(eoc), 32'd0);
        check("t6_chan", 32'(chan_out), 32'd0);
        repeat (8) tick();
        check("t6_no_drdy", 32'(drdy_count), 32'd0);
        s_valid = 1'b1; s_chan = 2'd2; s_data = 16'h0000;
        tick();
        s_valid = 1'b1; s_chan = 2'd2; s_data = 16'h4000;
        tick();
        tick();
        drp_op(1'b0, 7'h1F, 16'h0, rd, lat);
`ifdef DRP_SAMPLE_AVG_EN
        check("t6_avg", 32'(rd), 32'h1000);
`else
        check("t6_direct", 32'(rd), 32'h4000);
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                den = 1'b1;
                dwe = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 7))
                    0:       daddr = 7'h16;
                    1:       daddr = 7'h17;
                    2:       daddr = 7'h1E;
                    3:       daddr = 7'h1F;
                    4:       daddr = 7'h40;
                    5:       daddr = 7'h41;
                    6:       daddr = 7'h05;
                    default: daddr = 7'($urandom);
                endcase
                di = 16'($urandom);
                if (daddr == 7'h40) di[0] = ($urandom_range(0, 3) != 0);
            end
            s_valid = 1'($urandom_range(0, 1));
            s_chan  = 2'($urandom_range(0, 3));
            s_data  = 16'($urandom_range(0, 4095)) << 4;
            if ($urandom_range(0, 599) == 0) rst = 1'b1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
